// File: rtl/ucie_ctl_pkg.sv
// rtl/ucie_ctl_pkg.sv - shared encodings for the UCIe controller TX path
package ucie_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_OVERFLOW = 2'd2,
        ST_DRAIN    = 2'd3
    } tx_state_e;

    localparam logic [3:0] UCIE_STS_ACTIVE = 4'b0001;

    localparam int OVF_MODE_STICKY  = 0;
    localparam int OVF_MODE_RECOVER = 1;

endpackage

// File: rtl/ucie_sync_fifo.sv
// rtl/ucie_sync_fifo.sv - first-word-fall-through FIFO with level and synchronous flush
module ucie_sync_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(wr_ok) - LVL_W'(rd_ok);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ucie_ctl_tx_flow.sv
// rtl/ucie_ctl_tx_flow.sv - FDI-to-RDI TX flow controller with overflow and drain handling
module ucie_ctl_tx_flow
    import ucie_ctl_pkg::*;
#(
    parameter int         DATA_W        = 256,
    parameter int         DEPTH         = 8,
    parameter int         OVF_WAIT      = 1,
    parameter int         OVF_MODE      = 0,
    parameter int         DRAIN_ON_EXIT = 1,
    parameter int         DRAIN_TIMEOUT = 64,
    parameter int         CNT_W         = 8,
    parameter logic [3:0] UCIE_ACTIVE   = UCIE_STS_ACTIVE,
    localparam int        LVL_W         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        i_fdi_pl_state_sts,
    input  logic              i_fdi_lp_valid,
    input  logic              i_fdi_lp_irdy,
    input  logic [DATA_W-1:0] i_fdi_lp_data,
    output logic              o_fdi_pl_trdy,
    output logic              o_rdi_lp_valid,
    output logic              o_rdi_lp_irdy,
    output logic [DATA_W-1:0] o_rdi_lp_data,
    input  logic              i_rdi_pl_trdy,
    output logic              o_tx_overf_err,
    output logic [CNT_W-1:0]  o_ovf_cnt,
    output logic [LVL_W-1:0]  o_fifo_level,
    output logic              o_drain_abort,
    output logic [1:0]        o_state
);

    localparam int STALL_W = $clog2(OVF_WAIT + 1);
    localparam int TMR_W   = $clog2(DRAIN_TIMEOUT) + 1;

    tx_state_e          cs, ns;
    logic [LVL_W-1:0]   level, lvl_nxt;
    logic               full, empty, act;
    logic               wr_fire, rd_fire, stall, ovf_hit, drain_to;
    logic [STALL_W-1:0] stall_cnt, stall_nxt;
    logic [TMR_W-1:0]   drain_tmr, tmr_nxt;
    logic [CNT_W-1:0]   ovf_cnt;
    logic               drain_abort_q;
    logic [DATA_W-1:0]  head;

    ucie_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (cs == ST_IDLE),
        .wr_en   (wr_fire),
        .wr_data (i_fdi_lp_data),
        .rd_en   (rd_fire),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign act       = (i_fdi_pl_state_sts == UCIE_ACTIVE);
    assign wr_fire   = i_fdi_lp_valid & i_fdi_lp_irdy & o_fdi_pl_trdy;
    assign rd_fire   = o_rdi_lp_valid & i_rdi_pl_trdy;
    assign stall     = full & i_fdi_lp_valid & i_fdi_lp_irdy;
    assign stall_nxt = stall ? stall_cnt + STALL_W'(1) : '0;
    assign ovf_hit   = stall && (stall_nxt == STALL_W'(OVF_WAIT));
    assign tmr_nxt   = (cs == ST_DRAIN) ? drain_tmr + TMR_W'(1) : '0;
    assign drain_to  = (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1));
    assign lvl_nxt   = level + LVL_W'(wr_fire) - LVL_W'(rd_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs <= ST_IDLE;
        else        cs <= ns;
    end

    always_comb begin
        ns = cs;
        unique case (cs)
            ST_IDLE:     if (act) ns = ST_ACTIVE;
            ST_ACTIVE: begin
                if (!act)         ns = (DRAIN_ON_EXIT != 0) ? ST_DRAIN : ST_IDLE;
                else if (ovf_hit) ns = ST_OVERFLOW;
            end
            ST_OVERFLOW: begin
                if (!act)                                         ns = (DRAIN_ON_EXIT != 0) ? ST_DRAIN : ST_IDLE;
                else if (OVF_MODE == OVF_MODE_RECOVER && empty)   ns = ST_ACTIVE;
            end
            ST_DRAIN:    if (empty || drain_to) ns = ST_IDLE;
            default:     ns = ST_IDLE;
        endcase
    end

    always_comb begin
        o_fdi_pl_trdy  = 1'b0;
        o_rdi_lp_valid = 1'b0;
        o_tx_overf_err = 1'b0;
        unique case (cs)
            ST_ACTIVE: begin
                o_fdi_pl_trdy  = ~full;
                o_rdi_lp_valid = ~empty;
            end
            ST_OVERFLOW: begin
                o_rdi_lp_valid = ~empty;
                o_tx_overf_err = 1'b1;
            end
            ST_DRAIN:  o_rdi_lp_valid = ~empty;
            default:   ;
        endcase
    end

    // The abort flop is loaded with the timeout condition as it will stand next cycle,
    // so the registered pulse lines up with the last DRAIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            drain_tmr     <= '0;
            ovf_cnt       <= '0;
            drain_abort_q <= 1'b0;
        end else begin
            stall_cnt     <= (cs == ST_ACTIVE && ns == ST_ACTIVE) ? stall_nxt : '0;
            drain_tmr     <= (ns == ST_DRAIN) ? tmr_nxt : '0;
            drain_abort_q <= (ns == ST_DRAIN) && (tmr_nxt == TMR_W'(DRAIN_TIMEOUT - 1))
                             && (lvl_nxt != '0);
            if (cs == ST_ACTIVE && ns == ST_OVERFLOW && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

    assign o_rdi_lp_irdy = o_rdi_lp_valid;
    assign o_rdi_lp_data = o_rdi_lp_valid ? head : '0;
    assign o_fifo_level  = (cs == ST_IDLE) ? '0 : level;
    assign o_ovf_cnt     = ovf_cnt;
    assign o_drain_abort = drain_abort_q;
    assign o_state       = cs;

endmodule

// File: tb/tb_ucie_ctl_tx_flow.sv
// tb/tb_ucie_ctl_tx_flow.sv - self-checking bench for ucie_ctl_tx_flow
module tb_ucie_ctl_tx_flow;

    typedef struct packed {
        logic [1:0]  st;
        logic        trdy;
        logic        val;
        logic        irdy;
        logic [15:0] data;
        logic        err;
        logic [7:0]  cnt;
        logic [3:0]  lvl;
        logic        ab;
    } obs_t;

    typedef struct packed {
        logic [3:0] sts;
        logic       v;
        logic       rt;
        logic [1:0] st;
        logic [3:0] lvl;
        logic       trdy;
        logic       val;
        logic       err;
        logic       ab;
        logic [1:0] cnt;
    } vec_t;

    logic        clk, rst_n;
    logic [3:0]  fdi_sts;
    logic        lp_valid, lp_irdy, rdi_trdy;
    logic [15:0] lp_data;

    logic [2:0]  trdy_w, val_w, irdy_w, err_w, ab_w;
    logic [1:0]  st_w   [3];
    logic [15:0] data_w [3];
    logic [3:0]  lvl_w  [3];
    logic [1:0]  cnt_a;
    logic [7:0]  cnt_b, cnt_c;

    int n_chk = 0;
    int n_fail = 0;

    // Per-instance configuration: a = recovering/short timeout, b = sticky, c = flush on exit
    int p_wt[3]    = '{4, 1, 2};
    int p_mode[3]  = '{1, 0, 1};
    int p_drain[3] = '{1, 1, 0};
    int p_tmo[3]   = '{4, 64, 8};
    int p_cmax[3]  = '{3, 255, 255};

    int          m_st[3], m_n[3], m_stall[3], m_tmr[3], m_ovf[3];
    logic [15:0] m_q[3][8];

    vec_t        vt[$];
    logic [15:0] seq = 16'h1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ucie_ctl_tx_flow #(.DATA_W(16), .DEPTH(8), .OVF_WAIT(4), .OVF_MODE(1), .DRAIN_ON_EXIT(1),
                       .DRAIN_TIMEOUT(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_fdi_pl_state_sts(fdi_sts), .i_fdi_lp_valid(lp_valid),
        .i_fdi_lp_irdy(lp_irdy), .i_fdi_lp_data(lp_data), .o_fdi_pl_trdy(trdy_w[0]),
        .o_rdi_lp_valid(val_w[0]), .o_rdi_lp_irdy(irdy_w[0]), .o_rdi_lp_data(data_w[0]),
        .i_rdi_pl_trdy(rdi_trdy), .o_tx_overf_err(err_w[0]), .o_ovf_cnt(cnt_a),
        .o_fifo_level(lvl_w[0]), .o_drain_abort(ab_w[0]), .o_state(st_w[0]));

    ucie_ctl_tx_flow #(.DATA_W(16), .DEPTH(8), .OVF_WAIT(1), .OVF_MODE(0), .DRAIN_ON_EXIT(1),
                       .DRAIN_TIMEOUT(64), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_fdi_pl_state_sts(fdi_sts), .i_fdi_lp_valid(lp_valid),
        .i_fdi_lp_irdy(lp_irdy), .i_fdi_lp_data(lp_data), .o_fdi_pl_trdy(trdy_w[1]),
        .o_rdi_lp_valid(val_w[1]), .o_rdi_lp_irdy(irdy_w[1]), .o_rdi_lp_data(data_w[1]),
        .i_rdi_pl_trdy(rdi_trdy), .o_tx_overf_err(err_w[1]), .o_ovf_cnt(cnt_b),
        .o_fifo_level(lvl_w[1]), .o_drain_abort(ab_w[1]), .o_state(st_w[1]));

    ucie_ctl_tx_flow #(.DATA_W(16), .DEPTH(8), .OVF_WAIT(2), .OVF_MODE(1), .DRAIN_ON_EXIT(0),
                       .DRAIN_TIMEOUT(8), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_fdi_pl_state_sts(fdi_sts), .i_fdi_lp_valid(lp_valid),
        .i_fdi_lp_irdy(lp_irdy), .i_fdi_lp_data(lp_data), .o_fdi_pl_trdy(trdy_w[2]),
        .o_rdi_lp_valid(val_w[2]), .o_rdi_lp_irdy(irdy_w[2]), .o_rdi_lp_data(data_w[2]),
        .i_rdi_pl_trdy(rdi_trdy), .o_tx_overf_err(err_w[2]), .o_ovf_cnt(cnt_c),
        .o_fifo_level(lvl_w[2]), .o_drain_abort(ab_w[2]), .o_state(st_w[2]));

    function automatic obs_t dut_obs(input int k);
        logic [7:0] c;
        c = (k == 0) ? {6'd0, cnt_a} : (k == 1) ? cnt_b : cnt_c;
        return {st_w[k], trdy_w[k], val_w[k], irdy_w[k], data_w[k], err_w[k], c, lvl_w[k], ab_w[k]};
    endfunction

    function automatic obs_t mdl_obs(input int k);
        obs_t o;
        o      = '0;
        o.st   = 2'(m_st[k]);
        o.trdy = (m_st[k] == 1) && (m_n[k] < 8);
        o.val  = (m_st[k] != 0) && (m_n[k] > 0);
        o.irdy = o.val;
        o.data = o.val ? m_q[k][0] : 16'h0;
        o.err  = (m_st[k] == 2);
        o.cnt  = 8'(m_ovf[k]);
        o.lvl  = (m_st[k] == 0) ? 4'd0 : 4'(m_n[k]);
        o.ab   = (m_st[k] == 3) && (m_n[k] > 0) && (m_tmr[k] == p_tmo[k] - 1);
        return o;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_n[k] = 0; m_stall[k] = 0; m_tmr[k] = 0; m_ovf[k] = 0;
        end
    endtask

    // Reference behaviour: states as small integers, FIFO as a shift array.
    task automatic m_step(input int k, input bit act, input bit v, input bit ir,
                          input logic [15:0] d, input bit rt);
        int st0, n0, n, stl;
        bit wr, rd;
        st0 = m_st[k]; n0 = m_n[k]; n = n0; stl = 0;
        wr  = v && ir && (st0 == 1) && (n0 < 8);
        rd  = (st0 != 0) && (n0 > 0) && rt;
        if (rd) begin
            for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
            n--;
        end
        if (wr) begin
            m_q[k][n] = d;
            n++;
        end
        case (st0)
            0: begin
                n = 0;
                if (act) m_st[k] = 1;
            end
            1: begin
                stl = (n0 == 8 && v && ir) ? m_stall[k] + 1 : 0;
                if (!act) m_st[k] = (p_drain[k] != 0) ? 3 : 0;
                else if (stl >= p_wt[k]) begin
                    m_st[k] = 2;
                    if (m_ovf[k] < p_cmax[k]) m_ovf[k]++;
                end
            end
            2: begin
                if (!act) m_st[k] = (p_drain[k] != 0) ? 3 : 0;
                else if (p_mode[k] == 1 && n0 == 0) m_st[k] = 1;
            end
            default: if (n0 == 0 || m_tmr[k] == p_tmo[k] - 1) m_st[k] = 0;
        endcase
        m_stall[k] = (st0 == 1 && m_st[k] == 1) ? stl : 0;
        m_tmr[k]   = (st0 == 3 && m_st[k] == 3) ? m_tmr[k] + 1 : 0;
        m_n[k]     = n;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input logic [3:0] sts, input bit v, input bit ir,
                        input logic [15:0] d, input bit rt);
        obs_t a, e;
        fdi_sts = sts; lp_valid = v; lp_irdy = ir; lp_data = d; rdi_trdy = rt;
        #1;
        for (int k = 0; k < 3; k++) begin
            a = dut_obs(k);
            e = mdl_obs(k);
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model_dut%0d t=%0t: got %h expected %h", k, $time, a, e);
            end
        end
        for (int k = 0; k < 3; k++) m_step(k, sts == 4'b0001, v, ir, d, rt);
        seq = seq + 16'd1;
        @(negedge clk);
    endtask

    task automatic add(input int n, input logic [3:0] sts, input bit v, input bit rt,
                       input int st, input int lvl, input int dl, input bit trdy,
                       input bit val, input bit err, input bit ab, input int cnt);
        vec_t r;
        for (int i = 0; i < n; i++) begin
            r = {sts, v, rt, 2'(st), 4'(lvl + i * dl), trdy, val, err, ab, 2'(cnt)};
            vt.push_back(r);
        end
    endtask

    initial begin
        vec_t        r;
        logic [11:0] got, exp;

        rst_n = 1'b0; fdi_sts = 4'd0; lp_valid = 1'b0; lp_irdy = 1'b0;
        lp_data = 16'd0; rdi_trdy = 1'b0;
        m_reset();
        for (int k = 0; k < 3; k++) for (int i = 0; i < 8; i++) m_q[k][i] = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Expected dut_a behaviour: link-up streaming, fill, overflow, recover, drain abort
        //  n  sts v rt  st lvl dl trdy val err ab cnt
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(2, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(7, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        add(4, 1, 1, 0, 1, 8, 0, 0, 1, 0, 0, 0);
        add(8, 1, 1, 1, 2, 8, -1, 0, 1, 1, 0, 1);
        add(1, 1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 1);
        add(1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        add(5, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 6, 0, 1, 1, 0, 0, 1);
        add(3, 1, 0, 0, 3, 6, 0, 0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 3, 6, 0, 0, 1, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            r   = vt[i];
            got = {st_w[0], lvl_w[0], trdy_w[0], val_w[0], err_w[0], ab_w[0], cnt_a};
            exp = {r.st, r.lvl, r.trdy, r.val, r.err, r.ab, r.cnt};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec[%0d]: got %h expected %h", i, got, exp);
            end
            tick(r.sts, r.v, r.v, seq, r.rt);
        end

        // Sticky versus self-recovering overflow, then exit handling
        repeat (10) tick(4'd0, 0, 0, 16'h0, 1);
        tick(4'd1, 0, 0, 16'h0, 0);
        repeat (12) tick(4'd1, 1, 1, seq, 0);
        repeat (10) tick(4'd1, 0, 0, 16'h0, 1);
        chk("sticky_state_b", st_w[1], 2);
        chk("sticky_err_b", err_w[1], 1);
        chk("recover_state_a", st_w[0], 1);
        chk("recover_trdy_a", trdy_w[0], 1);
        tick(4'd0, 0, 0, 16'h0, 1);
        chk("exit_drain_b", st_w[1], 3);
        chk("exit_flush_c", st_w[2], 0);
        tick(4'd0, 0, 0, 16'h0, 1);
        chk("drain_empty_idle_b", st_w[1], 0);

        // Repeated overflow episodes push the 2-bit counter past its limit
        repeat (6) begin
            tick(4'd1, 0, 0, 16'h0, 0);
            repeat (12) tick(4'd1, 1, 1, seq, 0);
            tick(4'd1, 0, 0, 16'h0, 0);
            repeat (6) tick(4'd0, 0, 0, 16'h0, 0);
        end
        chk("ovf_sat_a", cnt_a, 3);

        // Asynchronous reset in the middle of a write burst
        repeat (3) tick(4'd1, 1, 1, seq, 1);
        fdi_sts = 4'd1; lp_valid = 1'b1; lp_irdy = 1'b1; rdi_trdy = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_rst_dut%0d", k), int'(dut_obs(k)), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0001,
                 ($urandom % 4) != 0, ($urandom % 4) != 0, 16'($urandom), ($urandom % 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_tx_flow.md
# ucie_ctl_tx_flow

Parametrised TX flow controller between the FDI (adapter side) and RDI (physical side) of the UCIe controller. It owns an internal first-word-fall-through FIFO of configurable width and depth and gates the FDI and RDI handshakes on the FDI link state. It adds features the previous TX FSM lacked:
- stall-tolerant overflow detection;
- selectable sticky or self-recovering overflow;
- a bounded drain of buffered flits when the link leaves Active;
- saturating overflow statistics.

## Interface
Parameters:
- DATA_W, 256, flit data width.
- DEPTH, 8, FIFO entries. Power of two, ≥2.
- OVF_WAIT, 1, consecutive full-stall cycles before overflow is declared (≥1).
- OVF_MODE, 0, overflow handling. 0 = sticky until link leaves Active; 1 = recover when the FIFO is empty.
- DRAIN_ON_EXIT, 1, selects drain behaviour on Active exit. 1 = drain the FIFO to RDI; 0 = flush immediately.
- DRAIN_TIMEOUT, 64, maximum cycles spent in DRAIN (≥1).
- CNT_W, 8, overflow counter width.
- UCIE_ACTIVE, 4'b0001, state_sts encoding for Active.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- i_fdi_pl_state_sts  in  4  link state
- i_fdi_lp_valid  in  1  FDI data valid
- i_fdi_lp_irdy  in  1  FDI initiator ready
- i_fdi_lp_data  in  DATA_W  FDI flit
- o_fdi_pl_trdy  out  1  FIFO accepts a write
- o_rdi_lp_valid  out  1  RDI data valid
- o_rdi_lp_irdy  out  1  RDI initiator ready (equal to o_rdi_lp_valid)
- o_rdi_lp_data  out  DATA_W  head of the FIFO
- i_rdi_pl_trdy  in  1  RDI target ready
- o_tx_overf_err  out  1  high while in OVERFLOW
- o_ovf_cnt  out  CNT_W  saturating count of OVERFLOW entries
- o_fifo_level  out  $clog2(DEPTH+1)  current occupancy
- o_drain_abort  out  1  one-cycle pulse when DRAIN times out with data left
- o_state  out  2  current state: IDLE=0, ACTIVE=1, OVERFLOW=2, DRAIN=3

## Operation
- Handshake definitions:
  - wr_fire = i_fdi_lp_valid & i_fdi_lp_irdy & o_fdi_pl_trdy.
  - rd_fire = o_rdi_lp_valid & i_rdi_pl_trdy.
  - act = (i_fdi_pl_state_sts == UCIE_ACTIVE).
- **IDLE**
  - All outputs 0 except o_ovf_cnt.
  - FIFO pointers and level are held cleared.
  - act → ACTIVE.
- **ACTIVE**
  - o_fdi_pl_trdy = !full.
  - o_rdi_lp_valid = o_rdi_lp_irdy = !empty.
  - Stall counter: increments each cycle full & lp_valid & lp_irdy holds; clears otherwise.
  - Stall counter reaching OVF_WAIT → OVERFLOW, and o_ovf_cnt increments, saturating at 2^CNT_W−1.
  - !act → DRAIN if DRAIN_ON_EXIT, else IDLE. This exit has priority over overflow.
- **OVERFLOW**
  - o_fdi_pl_trdy = 0; RDI keeps draining.
  - o_tx_overf_err = 1.
  - !act → DRAIN or IDLE, as from ACTIVE.
  - OVF_MODE=1 and empty → ACTIVE.
- **DRAIN**
  - o_fdi_pl_trdy = 0; RDI is valid while !empty.
  - A timer counts from 0 on entry.
  - empty → IDLE.
  - Timer reaching DRAIN_TIMEOUT−1 while !empty → IDLE, with o_drain_abort pulsed that cycle; the remaining data is flushed.
  - act has no effect in DRAIN. Re-entry to ACTIVE is always via IDLE.
- FIFO level arithmetic:
  - write only: +1.
  - read only: −1.
  - both: unchanged.
- Writes are never accepted when full; reads are never issued when empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from the level.

## Timing
- Reset: CS = IDLE, FIFO empty, counters 0, all outputs 0.
- IDLE → ACTIVE: act sampled in cycle n gives o_fdi_pl_trdy = 1 in cycle n+1.
- Write-to-read latency: wr_fire in cycle n makes the flit visible on o_rdi_lp_data, with valid, in cycle n+1.
- Full with simultaneous rd_fire: trdy stays 0 that cycle and rises the next cycle.
- Overflow detection:
  - OVF_WAIT=1: the first full stall cycle n gives o_tx_overf_err in cycle n+1.
  - A stall interrupted before OVF_WAIT restarts the count.
- Timing of status and pulse outputs:
  - o_tx_overf_err, o_fdi_pl_trdy and the o_rdi_lp_* signals decode from the state and FIFO flags, with no input-to-output combinational path except through the FIFO flags.
  - o_drain_abort is registered.
- Reset mid-operation: asynchronous return to IDLE, the FIFO contents are discarded, and o_ovf_cnt is cleared.

## Structure
- Shared package ucie_ctl_pkg holds:
  - the state encoding (IDLE/ACTIVE/OVERFLOW/DRAIN);
  - the UCIE_ACTIVE constant;
  - the OVF_MODE encodings.
- Sub-module ucie_sync_fifo:
  - parameters DATA_W and DEPTH;
  - FWFT;
  - level output;
  - synchronous flush input, driven when the controller is in IDLE.
- The top level contains the FSM, the stall counter, the drain timer and the statistics counter.

## Test plan
- Link up, write 3 flits with RDI trdy=1 → each flit appears on RDI 1 cycle later; level returns to 0; no error.
- DEPTH=8, RDI trdy=0, 8 writes → level 8, o_fdi_pl_trdy=0; with OVF_WAIT=4, holding valid&irdy for 4 cycles → o_tx_overf_err=1, o_ovf_cnt=1.
- OVF_MODE=1, in OVERFLOW, release RDI trdy → 8 reads, level 0 → ACTIVE next cycle; trdy=1, err=0.
- OVF_MODE=0 → OVERFLOW persists after empty until state_sts≠0001, then DRAIN→IDLE.
- DRAIN_TIMEOUT=4, 6 flits buffered, state_sts→0000, RDI trdy=0 → o_drain_abort pulses once; IDLE; level 0.
- CNT_W=2, 5 overflow episodes → o_ovf_cnt saturates at 3; rst_n low mid-write → all outputs 0 immediately.
